mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory arbiter between instruction fetch and the LSU. It has a one-entry
// LSU pending slot, rollback handling and UART back-pressure on I/O writes.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        en_signal_from_if,
    input  logic [31:0] addr_from_if,
    output logic        ok_flag_to_if,
    output logic [31:0] data_to_if,
    input  logic        en_signal_from_lsu,
    input  logic        rw_flag_from_lsu,
    input  logic [2:0]  size_from_lsu,
    input  logic [31:0] addr_from_lsu,
    input  logic [31:0] data_from_lsu,
    output logic        ok_flag_to_lsu,
    output logic [31:0] data_to_lsu,
    input  logic        rollback_flag_from_rob,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, IF_READ, LSU_READ, LSU_WRITE} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d, size_q, size_d;
    logic [31:0] base_q, base_d, buf_q, buf_d;
    logic        slot_vld_q, slot_vld_d, slot_rw_q, slot_rw_d;
    logic [2:0]  slot_size_q, slot_size_d;
    logic [31:0] slot_addr_q, slot_addr_d, slot_data_q, slot_data_d;
    logic        if_ok_q, if_ok_d, lsu_ok_q, lsu_ok_d;
    logic [31:0] if_data_q, if_data_d, lsu_data_q, lsu_data_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;

    // Working copy of the transaction being advanced on this edge
    logic        run, size_ok, inc_eff, slot_eff;
    state_e      run_state;
    logic [31:0] run_base, run_buf, step_addr;
    logic [2:0]  run_size, run_cnt;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        base_d      = base_q;
        buf_d       = buf_q;
        slot_rw_d   = slot_rw_q;
        slot_size_d = slot_size_q;
        slot_addr_d = slot_addr_q;
        slot_data_d = slot_data_q;
        if_ok_d     = 1'b0;
        lsu_ok_d    = 1'b0;
        if_data_d   = if_data_q;
        lsu_data_d  = lsu_data_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = 1'b0;
        run         = 1'b0;
        run_state   = state_q;
        run_base    = base_q;
        run_size    = size_q;
        run_cnt     = cnt_q;
        run_buf     = buf_q;
        step_addr   = '0;

        // Rollback kills loads (pending or arriving) but never stores
        size_ok    = (size_from_lsu == 3'd1) || (size_from_lsu == 3'd2) || (size_from_lsu == 3'd4);
        inc_eff    = en_signal_from_lsu && size_ok && !(rollback_flag_from_rob && !rw_flag_from_lsu);
        slot_eff   = slot_vld_q && !(rollback_flag_from_rob && !slot_rw_q);
        slot_vld_d = slot_eff;

        if (state_q == IDLE) begin
            if (slot_eff) begin
                run        = 1'b1;
                run_state  = slot_rw_q ? LSU_WRITE : LSU_READ;
                run_base   = slot_addr_q;
                run_size   = slot_size_q;
                run_buf    = slot_rw_q ? slot_data_q : '0;
                run_cnt    = 3'd0;
                slot_vld_d = 1'b0;
            end else if (inc_eff) begin
                run       = 1'b1;
                run_state = rw_flag_from_lsu ? LSU_WRITE : LSU_READ;
                run_base  = addr_from_lsu;
                run_size  = size_from_lsu;
                run_buf   = rw_flag_from_lsu ? data_from_lsu : '0;
                run_cnt   = 3'd0;
            end else if (en_signal_from_if && !rollback_flag_from_rob) begin
                run       = 1'b1;
                run_state = IF_READ;
                run_base  = addr_from_if;
                run_size  = 3'd4;
                run_buf   = '0;
                run_cnt   = 3'd0;
            end
        end else if (rollback_flag_from_rob && state_q != LSU_WRITE) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
        end else begin
            run = 1'b1;
        end

        if (inc_eff && !(state_q == IDLE && !slot_eff)) begin
            slot_vld_d  = 1'b1;
            slot_rw_d   = rw_flag_from_lsu;
            slot_size_d = size_from_lsu;
            slot_addr_d = addr_from_lsu;
            slot_data_d = data_from_lsu;
        end

        if (run) begin
            state_d   = run_state;
            base_d    = run_base;
            size_d    = run_size;
            cnt_d     = run_cnt;
            step_addr = run_base + {29'd0, run_cnt};
            if (run_state == LSU_WRITE) begin
                if (run_cnt == run_size) begin
                    lsu_ok_d = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = 3'd0;
                end else if (!(step_addr[17:16] == 2'b11 && io_buffer_full)) begin
                    mem_a_d  = step_addr;
                    mem_wr_d = 1'b1;
                    cnt_d    = run_cnt + 3'd1;
                    case (run_cnt[1:0])
                        2'd0:    mem_dout_d = run_buf[7:0];
                        2'd1:    mem_dout_d = run_buf[15:8];
                        2'd2:    mem_dout_d = run_buf[23:16];
                        default: mem_dout_d = run_buf[31:24];
                    endcase
                end
            end else begin
                // mem_din belongs to the address presented on the previous edge
                case (run_cnt)
                    3'd1:    run_buf[7:0]   = mem_din;
                    3'd2:    run_buf[15:8]  = mem_din;
                    3'd3:    run_buf[23:16] = mem_din;
                    3'd4:    run_buf[31:24] = mem_din;
                    default: ;
                endcase
                if (run_cnt == run_size) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                    if (run_state == IF_READ) begin
                        if_ok_d   = 1'b1;
                        if_data_d = run_buf;
                    end else begin
                        lsu_ok_d   = 1'b1;
                        lsu_data_d = run_buf;
                    end
                end else begin
                    mem_a_d = step_addr;
                    cnt_d   = run_cnt + 3'd1;
                end
            end
            buf_d = run_buf;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            size_q      <= '0;
            base_q      <= '0;
            buf_q       <= '0;
            slot_vld_q  <= 1'b0;
            slot_rw_q   <= 1'b0;
            slot_size_q <= '0;
            slot_addr_q <= '0;
            slot_data_q <= '0;
            if_ok_q     <= 1'b0;
            lsu_ok_q    <= 1'b0;
            if_data_q   <= '0;
            lsu_data_q  <= '0;
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            mem_wr_q    <= 1'b0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            base_q      <= base_d;
            buf_q       <= buf_d;
            slot_vld_q  <= slot_vld_d;
            slot_rw_q   <= slot_rw_d;
            slot_size_q <= slot_size_d;
            slot_addr_q <= slot_addr_d;
            slot_data_q <= slot_data_d;
            if_ok_q     <= if_ok_d;
            lsu_ok_q    <= lsu_ok_d;
            if_data_q   <= if_data_d;
            lsu_data_q  <= lsu_data_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
        end
    end

    assign ok_flag_to_if  = if_ok_q;
    assign data_to_if     = if_data_q;
    assign ok_flag_to_lsu = lsu_ok_q;
    assign data_to_lsu    = lsu_data_q;
    assign mem_a          = mem_a_q;
    assign mem_dout       = mem_dout_q;
    assign mem_wr         = mem_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized self-checking bench for mem_ctrl. It uses a byte-array reference memory and
// a RAM model with a combinational read port.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        en_signal_from_if;
    logic [31:0] addr_from_if;
    logic        ok_flag_to_if;
    logic [31:0] data_to_if;
    logic        en_signal_from_lsu, rw_flag_from_lsu;
    logic [2:0]  size_from_lsu;
    logic [31:0] addr_from_lsu, data_from_lsu;
    logic        ok_flag_to_lsu;
    logic [31:0] data_to_lsu;
    logic        rollback_flag_from_rob;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    localparam int MEM_BYTES = 262144;

    logic [7:0]  pre_mem [0:MEM_BYTES-1];   // initial RAM contents
    logic [7:0]  ram_wr  [0:MEM_BYTES-1];   // bytes written by the DUT
    bit          wr_flag [0:MEM_BYTES-1];
    logic [7:0]  ref_mem [0:MEM_BYTES-1];   // expected memory image
    logic [31:0] wr_a [$];
    logic [7:0]  wr_d [$];

    int n_checks = 0;
    int n_errors = 0;

    mem_ctrl dut (
        .clk_in                 (clk_in),
        .rst_in                 (rst_in),
        .rdy_in                 (rdy_in),
        .en_signal_from_if      (en_signal_from_if),
        .addr_from_if           (addr_from_if),
        .ok_flag_to_if          (ok_flag_to_if),
        .data_to_if             (data_to_if),
        .en_signal_from_lsu     (en_signal_from_lsu),
        .rw_flag_from_lsu       (rw_flag_from_lsu),
        .size_from_lsu          (size_from_lsu),
        .addr_from_lsu          (addr_from_lsu),
        .data_from_lsu          (data_from_lsu),
        .ok_flag_to_lsu         (ok_flag_to_lsu),
        .data_to_lsu            (data_to_lsu),
        .rollback_flag_from_rob (rollback_flag_from_rob),
        .mem_din                (mem_din),
        .mem_dout               (mem_dout),
        .mem_a                  (mem_a),
        .mem_wr                 (mem_wr),
        .io_buffer_full         (io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    assign mem_din = wr_flag[mem_a[17:0]] ? ram_wr[mem_a[17:0]] : pre_mem[mem_a[17:0]];

    always @(posedge clk_in) begin
        if (mem_wr) begin
            ram_wr[mem_a[17:0]]  <= mem_dout;
            wr_flag[mem_a[17:0]] <= 1'b1;
            wr_a.push_back(mem_a);
            wr_d.push_back(mem_dout);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic poke(input int a, input logic [7:0] d);
        pre_mem[a] = d;
        ref_mem[a] = d;
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] addr, input int n);
        logic [31:0] w;
        int a;
        w = '0;
        a = int'(addr[17:0]);
        for (int i = 0; i < n; i++) w = w | (32'(ref_mem[a + i]) << (8 * i));
        return w;
    endfunction

    // One LSU access; rb_at/stall_at give the cycle (1-based after the pulse) at which to
    // pulse rollback or drop rdy_in for three cycles (0 = never)
    task automatic lsu_txn(input string tag, input logic rw, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] data,
                           input int rb_at, input int stall_at);
        logic [31:0] exp_d, got_d;
        int lat, exp_lat, start, a, nw;
        exp_d = ref_word(addr, int'(size));
        start = wr_a.size();
        en_signal_from_lsu = 1'b1;
        rw_flag_from_lsu   = rw;
        size_from_lsu      = size;
        addr_from_lsu      = addr;
        data_from_lsu      = data;
        lat = 0;
        do begin
            @(negedge clk_in);
            lat++;
            if (lat == 1) en_signal_from_lsu = 1'b0;
            rollback_flag_from_rob = (lat == rb_at);
            if (lat == stall_at) rdy_in = 1'b0;
            if (lat == stall_at + 3) rdy_in = 1'b1;
        end while (!ok_flag_to_lsu && lat < 60);
        rollback_flag_from_rob = 1'b0;
        rdy_in = 1'b1;
        got_d = data_to_lsu;
        exp_lat = int'(size) + 1 + ((stall_at > 0) ? 3 : 0);
        check_val({tag, "_lat"}, lat, exp_lat);
        if (!rw) check_val({tag, "_data"}, got_d, exp_d);
        @(negedge clk_in);
        check_val({tag, "_okpulse"}, {31'd0, ok_flag_to_lsu}, 32'd0);
        nw = wr_a.size() - start;
        check_val({tag, "_nwr"}, nw, rw ? int'(size) : 0);
        if (rw) begin
            a = int'(addr[17:0]);
            for (int i = 0; i < int'(size) && i < nw; i++) begin
                check_val({tag, "_wa"}, wr_a[start + i], addr + 32'(i));
                check_val({tag, "_wd"}, {24'd0, wr_d[start + i]}, {24'd0, data[8*i +: 8]});
            end
            for (int i = 0; i < int'(size); i++) ref_mem[a + i] = data[8*i +: 8];
        end
        $display("TXN %s rw=%0d size=%0d addr=%h wdata=%h rdata=%h lat=%0d",
                 tag, rw, size, addr, data, got_d, lat);
    endtask

    task automatic if_txn(input string tag, input logic [31:0] addr, output logic [31:0] got);
        logic [31:0] exp_d;
        logic [31:0] seen_a [4];
        int lat;
        exp_d = ref_word(addr, 4);
        en_signal_from_if = 1'b1;
        addr_from_if      = addr;
        lat = 0;
        do begin
            @(negedge clk_in);
            lat++;
            if (lat <= 4) seen_a[lat-1] = mem_a;
        end while (!ok_flag_to_if && lat < 60);
        en_signal_from_if = 1'b0;
        got = data_to_if;
        check_val({tag, "_lat"}, lat, 5);
        check_val({tag, "_data"}, got, exp_d);
        for (int k = 0; k < 4; k++) check_val({tag, "_addr"}, seen_a[k], addr + 32'(k));
        @(negedge clk_in);
        check_val({tag, "_okpulse"}, {31'd0, ok_flag_to_if}, 32'd0);
        $display("TXN %s ifetch addr=%h data=%h lat=%0d", tag, addr, got, lat);
    endtask

    // Load aborted by rollback; no ok may follow
    task automatic lsu_abort(input string tag, input logic [31:0] addr, input int rb_at);
        int oks;
        oks = 0;
        en_signal_from_lsu = 1'b1;
        rw_flag_from_lsu   = 1'b0;
        size_from_lsu      = 3'd4;
        addr_from_lsu      = addr;
        for (int lat = 1; lat <= 10; lat++) begin
            @(negedge clk_in);
            if (lat == 1) en_signal_from_lsu = 1'b0;
            oks += int'(ok_flag_to_lsu);
            rollback_flag_from_rob = (lat == rb_at);
        end
        rollback_flag_from_rob = 1'b0;
        check_val({tag, "_no_ok"}, oks, 0);
        $display("TXN %s aborted load addr=%h rollback_cycle=%0d", tag, addr, rb_at);
    endtask

    initial begin
        logic [31:0] d, lsu_d, if_d, exp_if;
        int lat, lsu_lat, if_lat, start, oks, diffs, n;
        logic rw;
        logic [2:0] sz;
        logic [31:0] ad;

        for (int i = 0; i < MEM_BYTES; i++) begin
            pre_mem[i] = 8'($urandom);
            ref_mem[i] = pre_mem[i];
        end
        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
        poke(32'h40, 8'h80);

        rst_in = 1'b1; rdy_in = 1'b1;
        en_signal_from_if = 1'b0; addr_from_if = '0;
        en_signal_from_lsu = 1'b0; rw_flag_from_lsu = 1'b0; size_from_lsu = '0;
        addr_from_lsu = '0; data_from_lsu = '0;
        rollback_flag_from_rob = 1'b0; io_buffer_full = 1'b0;
        repeat (3) @(negedge clk_in);
        check_val("rst_ok_if", {31'd0, ok_flag_to_if}, 32'd0);
        check_val("rst_ok_lsu", {31'd0, ok_flag_to_lsu}, 32'd0);
        check_val("rst_data_if", data_to_if, 32'd0);
        check_val("rst_data_lsu", data_to_lsu, 32'd0);
        check_val("rst_mem_a", mem_a, 32'd0);
        check_val("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        check_val("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);

        if_txn("ifetch_0x100", 32'h100, d);
        check_val("ifetch_0x100_word", d, 32'h0000_0513);

        lsu_txn("sh_0x2000", 1'b1, 3'd2, 32'h2000, 32'hDEAD_BEEF, 0, 0);

        // IF and LB in the same cycle: LSU first, IF after one idle cycle
        exp_if = ref_word(32'h1010, 4);
        en_signal_from_if = 1'b1; addr_from_if = 32'h1010;
        en_signal_from_lsu = 1'b1; rw_flag_from_lsu = 1'b0; size_from_lsu = 3'd1;
        addr_from_lsu = 32'h40;
        lat = 0; lsu_lat = 0; if_lat = 0; lsu_d = '0; if_d = '0;
        do begin
            @(negedge clk_in);
            lat++;
            if (lat == 1) en_signal_from_lsu = 1'b0;
            if (ok_flag_to_lsu) begin lsu_lat = lat; lsu_d = data_to_lsu; end
            if (ok_flag_to_if) begin if_lat = lat; if_d = data_to_if; en_signal_from_if = 1'b0; end
        end while (if_lat == 0 && lat < 60);
        en_signal_from_if = 1'b0;
        check_val("arb_lsu_lat", lsu_lat, 2);
        check_val("arb_lsu_data", lsu_d, 32'h0000_0080);
        check_val("arb_if_lat", if_lat, 7);
        check_val("arb_if_data", if_d, exp_if);
        $display("TXN arb lb=%h at %0d ifetch=%h at %0d", lsu_d, lsu_lat, if_d, if_lat);
        @(negedge clk_in);

        // SB to UART while its buffer is full for three edges
        start = wr_a.size();
        io_buffer_full = 1'b1;
        en_signal_from_lsu = 1'b1; rw_flag_from_lsu = 1'b1; size_from_lsu = 3'd1;
        addr_from_lsu = 32'h0003_0000; data_from_lsu = 32'h0000_00A5;
        @(negedge clk_in); en_signal_from_lsu = 1'b0;
        check_val("io_stall0", {31'd0, mem_wr}, 32'd0);
        @(negedge clk_in);
        check_val("io_stall1", {31'd0, mem_wr}, 32'd0);
        @(negedge clk_in);
        check_val("io_stall2", {31'd0, mem_wr}, 32'd0);
        io_buffer_full = 1'b0;
        @(negedge clk_in);
        check_val("io_wr", {31'd0, mem_wr}, 32'd1);
        check_val("io_addr", mem_a, 32'h0003_0000);
        check_val("io_dout", {24'd0, mem_dout}, 32'h0000_00A5);
        @(negedge clk_in);
        check_val("io_ok", {31'd0, ok_flag_to_lsu}, 32'd1);
        check_val("io_wr_end", {31'd0, mem_wr}, 32'd0);
        @(negedge clk_in);
        check_val("io_okpulse", {31'd0, ok_flag_to_lsu}, 32'd0);
        check_val("io_nwr", wr_a.size() - start, 1);
        ref_mem[32'h30000] = 8'hA5;
        $display("TXN sb_io addr=00030000 data=a5");

        // Rollback: loads aborted (mid-way and on the completing edge), stores survive
        lsu_abort("lw_rb_cnt2", 32'h1200, 2);
        lsu_txn("lb_after_rb", 1'b0, 3'd1, 32'h1201, 32'd0, 0, 0);
        lsu_abort("lw_rb_last", 32'h1204, 4);
        lsu_txn("lh_after_rb", 1'b0, 3'd2, 32'h1206, 32'd0, 0, 0);
        lsu_txn("sw_rb", 1'b1, 3'd4, 32'h1180, 32'h1234_5678, 2, 0);

        // Unsupported sizes are dropped silently
        for (int k = 0; k < 3; k++) begin
            start = wr_a.size(); oks = 0;
            en_signal_from_lsu = 1'b1; rw_flag_from_lsu = 1'b1;
            size_from_lsu = (k == 0) ? 3'd3 : ((k == 1) ? 3'd0 : 3'd7);
            addr_from_lsu = 32'h1300; data_from_lsu = 32'hFFFF_FFFF;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk_in);
                if (c == 0) en_signal_from_lsu = 1'b0;
                oks += int'(ok_flag_to_lsu);
            end
            check_val("badsize_no_ok", oks, 0);
            check_val("badsize_no_wr", wr_a.size() - start, 0);
            $display("TXN badsize size=%0d dropped", size_from_lsu);
        end
        lsu_txn("lw_after_badsize", 1'b0, 3'd4, 32'h1300, 32'd0, 0, 0);

        lsu_txn("lw_rdy_freeze", 1'b0, 3'd4, 32'h1020, 32'd0, 0, 2);

        // Reset in the middle of a store
        en_signal_from_lsu = 1'b1; rw_flag_from_lsu = 1'b1; size_from_lsu = 3'd4;
        addr_from_lsu = 32'h2100; data_from_lsu = 32'hCAFE_F00D;
        @(negedge clk_in); en_signal_from_lsu = 1'b0;
        @(negedge clk_in); rst_in = 1'b1;
        @(negedge clk_in);
        check_val("rst_mid_mem_wr", {31'd0, mem_wr}, 32'd0);
        check_val("rst_mid_ok_lsu", {31'd0, ok_flag_to_lsu}, 32'd0);
        check_val("rst_mid_ok_if", {31'd0, ok_flag_to_if}, 32'd0);
        check_val("rst_mid_data_if", data_to_if, 32'd0);
        rst_in = 1'b0;
        $display("TXN reset_mid_store");
        @(negedge clk_in);
        if_txn("ifetch_after_rst", 32'h100, d);

        // Random traffic in a scratch window
        for (int t = 0; t < 150; t++) begin
            n = $urandom_range(0, 6);
            ad = 32'h1000 + 32'($urandom_range(0, 252));
            if (n == 0) begin
                if_txn("rnd_if", ad, d);
            end else begin
                rw = 1'($urandom_range(0, 1));
                sz = (n <= 2) ? 3'd1 : ((n <= 4) ? 3'd2 : 3'd4);
                if (rw)
                    lsu_txn("rnd_st", rw, sz, ad, $urandom,
                            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, int'(sz))) : 0, 0);
                else
                    lsu_txn("rnd_ld", rw, sz, ad, 32'd0, 0,
                            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, int'(sz))) : 0);
            end
        end

        diffs = 0;
        for (int i = 32'h1000; i < 32'h1104; i++)
            if ((wr_flag[i] ? ram_wr[i] : pre_mem[i]) !== ref_mem[i]) diffs++;
        check_val("ram_image_diffs", diffs, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
